// File: rtl/wave_oscillator.sv
// Phase-accumulator oscillator: saw-up/down, triangle and square from one DDS accumulator.
// Optional glitch-free mode/duty switching at phase wrap under WAVE_OSC_SYNC_SWITCH_EN.
module wave_oscillator #(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] ftw_in,
  input  logic             ftw_load,
  input  logic [1:0]       mode,
  input  logic [OUT_W-1:0] duty,
  input  logic             sync,
  output logic [OUT_W-1:0] wave_out,
  output logic             wrap
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic [1:0]       mode_q, mode_d;
  logic [OUT_W-1:0] duty_q, duty_d;
  logic [OUT_W-1:0] wave_q, wave_d;
  logic             wrap_q, wrap_d;
  logic [SUM_W-1:0] sum_c;
  logic [1:0]       mode_use_c;
  logic [OUT_W-1:0] duty_use_c;

`ifdef WAVE_OSC_SYNC_SWITCH_EN
  logic [1:0]       mode_pend_q;
  logic [OUT_W-1:0] duty_pend_q;
  logic             switch_c;
`endif

  // Map an accumulator value onto one output sample for the given mode and duty.
  function automatic logic [OUT_W-1:0] shape(input logic [ACC_W-1:0] a,
                                              input logic [1:0]       m,
                                              input logic [OUT_W-1:0] d);
    logic [OUT_W-1:0] p;
    logic [OUT_W-1:0] t;
    p = a[ACC_W-1 -: OUT_W];
    t = {p[OUT_W-2:0], 1'b0};
    case (m)
      2'b00:   shape = p;
      2'b01:   shape = ~p;
      2'b10:   shape = p[OUT_W-1] ? ~t : t;
      default: shape = (p < d) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    endcase
  endfunction

  assign sum_c = SUM_W'(acc_q) + SUM_W'(ftw_q);

`ifdef WAVE_OSC_SYNC_SWITCH_EN
  // Pending shape settings take over only on a wrap or sync edge.
  assign switch_c   = sync | (enable & sum_c[ACC_W]);
  assign mode_use_c = switch_c ? mode_pend_q : mode_q;
  assign duty_use_c = switch_c ? duty_pend_q : duty_q;
`else
  assign mode_use_c = mode_q;
  assign duty_use_c = duty_q;
`endif

  always_comb begin
    acc_d  = acc_q;
    wave_d = wave_q;
    wrap_d = 1'b0;
    ftw_d  = ftw_load ? ftw_in : ftw_q;
`ifdef WAVE_OSC_SYNC_SWITCH_EN
    mode_d = mode_use_c;
    duty_d = duty_use_c;
`else
    mode_d = mode;
    duty_d = duty;
`endif
    if (sync) begin
      acc_d  = '0;
      wave_d = shape('0, mode_use_c, duty_use_c);
    end else if (enable) begin
      acc_d  = sum_c[ACC_W-1:0];
      wrap_d = sum_c[ACC_W];
      wave_d = shape(sum_c[ACC_W-1:0], mode_use_c, duty_use_c);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      ftw_q  <= '0;
      mode_q <= '0;
      duty_q <= '0;
      wave_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ftw_q  <= ftw_d;
      mode_q <= mode_d;
      duty_q <= duty_d;
      wave_q <= wave_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef WAVE_OSC_SYNC_SWITCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_pend_q <= '0;
      duty_pend_q <= '0;
    end else begin
      mode_pend_q <= mode;
      duty_pend_q <= duty;
    end
  end
`endif

  assign wave_out = wave_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_wave_oscillator.sv
// Directed bench for wave_oscillator (OUT_W=8, ACC_W=16); follows WAVE_OSC_SYNC_SWITCH_EN if defined.
module tb_wave_oscillator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] ftw_in;
  logic        ftw_load;
  logic [1:0]  mode;
  logic [7:0]  duty;
  logic        sync;
  logic [7:0]  wave_out;
  logic        wrap;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wave_oscillator #(.OUT_W(8), .ACC_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .ftw_in   (ftw_in),
    .ftw_load (ftw_load),
    .mode     (mode),
    .duty     (duty),
    .sync     (sync),
    .wave_out (wave_out),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Hand-derived expected sample for an 8-bit phase p.
  function automatic int unsigned ref_wave(input int unsigned m, input int unsigned p,
                                           input int unsigned d);
    case (m)
      0:       return p;
      1:       return 255 - p;
      2:       return (p < 128) ? 2 * p : 2 * (255 - p) + 1;
      default: return (p < d) ? 255 : 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present new shape settings for one idle edge, then hard-sync so they apply from phase 0.
  task automatic setup(input logic [1:0] m, input logic [7:0] d);
    mode   = m;
    duty   = d;
    enable = 1'b0;
    sync   = 1'b0;
    tick();
    sync = 1'b1;
    tick();
    check("sync_sample", wave_out, ref_wave(m, 0, d));
    check("sync_wrap", wrap, 0);
    sync   = 1'b0;
    enable = 1'b1;
  endtask

  task automatic load_ftw(input logic [15:0] f);
    ftw_in   = f;
    ftw_load = 1'b1;
    enable   = 1'b0;
    tick();
    ftw_load = 1'b0;
  endtask

  initial begin
    int unsigned exp;
    reset_n  = 1'b0;
    enable   = 1'b0;
    ftw_in   = '0;
    ftw_load = 1'b0;
    mode     = 2'b00;
    duty     = '0;
    sync     = 1'b0;

    // Reset state, including while the clock runs.
    repeat (3) tick();
    check("rst_wave", wave_out, 0);
    check("rst_wrap", wrap, 0);
    reset_n = 1'b1;

    // Saw-up ramp with wrap only on the 0 sample.
    load_ftw(16'h0100);
    check("idle_wave", wave_out, 0);
    enable = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      check("saw_up", wave_out, i % 256);
      check("saw_wrap", wrap, (i == 256) ? 1 : 0);
    end

    // Triangle.
    setup(2'b10, 8'd0);
    for (int i = 1; i <= 256; i++) begin
      tick();
      check("tri", wave_out, ref_wave(2, i % 256, 0));
      check("tri_wrap", wrap, (i == 256) ? 1 : 0);
    end

    // Saw-down spot checks.
    setup(2'b01, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("saw_down", wave_out, 255 - i);
    end

    // Square with duty 64.
    setup(2'b11, 8'd64);
    for (int i = 1; i <= 256; i++) begin
      tick();
      check("sq64", wave_out, ref_wave(3, i % 256, 64));
    end

    // Square with duty 0 stays low.
    setup(2'b11, 8'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("sq0", wave_out, 0);
    end

    // Sync mid-ramp at p=100.
    setup(2'b00, 8'd0);
    for (int i = 1; i <= 100; i++) tick();
    check("pre_sync", wave_out, 100);
    sync = 1'b1;
    tick();
    check("sync_mid_wave", wave_out, 0);
    check("sync_mid_wrap", wrap, 0);
    sync = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    check("post_sync", wave_out, 5);

    // Enable low holds the sample.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_wave", wave_out, 5);
      check("hold_wrap", wrap, 0);
    end

    // FTW change: load edge still steps by the old word.
    enable   = 1'b1;
    ftw_in   = 16'h0200;
    ftw_load = 1'b1;
    tick();
    check("load_step_old", wave_out, 6);
    ftw_load = 1'b0;
    tick();
    check("load_step_new1", wave_out, 8);
    tick();
    check("load_step_new2", wave_out, 10);

    // Mode switch saw->square at p=10.
    load_ftw(16'h0100);
    setup(2'b00, 8'd0);
    for (int i = 1; i <= 10; i++) tick();
    check("pre_switch", wave_out, 10);
    mode = 2'b11;
    duty = 8'd64;
    for (int i = 11; i <= 266; i++) begin
      tick();
`ifdef WAVE_OSC_SYNC_SWITCH_EN
      exp = (i < 256) ? i : ref_wave(3, i % 256, 64);
`else
      exp = (i == 11) ? 11 : ref_wave(3, i % 256, 64);
`endif
      check("mode_switch", wave_out, exp);
      check("switch_wrap", wrap, (i == 256) ? 1 : 0);
    end

    // Asynchronous reset mid-ramp clears outputs without an edge.
    mode = 2'b00;
    duty = 8'd0;
    check("pre_areset", wave_out, 255);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("areset_wave", wave_out, 0);
    check("areset_wrap", wrap, 0);
    #3;
    reset_n = 1'b1;
    load_ftw(16'h0100);
    check("rel_idle", wave_out, 0);
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("rel_ramp", wave_out, i);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
